// File: rtl/ub_read_streamer.sv
`default_nettype none
// ============================================================================
// Module   : ub_read_streamer
// Purpose  : Streams a contiguous run of Unified Buffer words onto a
//            valid/ready interface through a 3-entry skid FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ub_read_streamer #(
    parameter int ADDRESSSIZE = 10,
    parameter int WORDSIZE    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE:0]   length,
    output logic                   busy,
    output logic                   done,
    output logic                   ub_rd_en,
    output logic [ADDRESSSIZE-1:0] ub_address,
    input  logic [WORDSIZE-1:0]    ub_data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDSIZE-1:0]    out_data,
    output logic                   out_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [2:0] c_FIFO_DEPTH = 3'd3;

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_rd_en;
    logic [ADDRESSSIZE-1:0] r_address;
    logic [ADDRESSSIZE:0]   r_issue_left;
    logic                   r_inflight;
    logic                   r_inflight_last;
    logic [WORDSIZE-1:0]    r_fifo_data [3];
    logic [2:0]             r_fifo_last;
    logic [1:0]             r_wr_ptr;
    logic [1:0]             r_rd_ptr;
    logic [1:0]             r_count;

    logic                   w_push;
    logic                   w_pop;
    logic [1:0]             w_count_next;
    logic                   w_issue_last;
    logic [ADDRESSSIZE:0]   w_issue_left_next;
    logic                   w_can_issue;

    function automatic logic [1:0] f_next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_push = r_inflight;
    assign w_pop  = out_valid & out_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    assign w_issue_last      = r_rd_en && (r_issue_left == (ADDRESSSIZE+1)'(1));
    assign w_issue_left_next = r_rd_en ? r_issue_left - (ADDRESSSIZE+1)'(1) : r_issue_left;

    // Next-cycle issue decision uses next-cycle occupancy, so ub_rd_en stays a
    // flop output while still reserving a slot for the read now in flight.
    assign w_can_issue = (w_issue_left_next != '0) &&
                         (({1'b0, w_count_next} + {2'b00, r_rd_en}) < c_FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_rd_en         <= 1'b0;
            r_address       <= '0;
            r_issue_left    <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_fifo_data[i] <= '0;
            end
            r_fifo_last     <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= r_rd_en;
            r_inflight_last <= w_issue_last;
            r_count         <= w_count_next;

            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= ub_data_out;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end

            case (r_state)
                S_IDLE: begin
                    r_rd_en <= 1'b0;
                    if (start) begin
                        if (length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state      <= S_RUN;
                            r_busy       <= 1'b1;
                            r_rd_en      <= 1'b1;
                            r_address    <= base_addr;
                            r_issue_left <= length;
                        end
                    end
                end
                S_RUN: begin
                    if (r_rd_en) begin
                        r_address    <= r_address + ADDRESSSIZE'(1);
                        r_issue_left <= w_issue_left_next;
                    end
                    if (w_issue_last) begin
                        r_state <= S_DRAIN;
                    end
                    r_rd_en <= w_can_issue;
                end
                S_DRAIN: begin
                    r_rd_en <= 1'b0;
                    if (w_pop && out_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rd_en <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign ub_rd_en   = r_rd_en;
    assign ub_address = r_address;
    assign out_valid  = (r_count != 2'd0);
    assign out_data   = r_fifo_data[r_rd_ptr];
    assign out_last   = out_valid & r_fifo_last[r_rd_ptr];

endmodule
`default_nettype wire

// File: doc/ub_read_streamer.md
# ub_read_streamer

Read-side sequencer for the Unified Buffer SRAM. On a start command it reads a contiguous run of 64-bit words and presents them on a valid/ready stream toward the systolic-array input stage. A 3-entry internal FIFO absorbs downstream backpressure and the SRAM's one-cycle registered read latency, so the stream sustains one word per cycle.

## Interface
- ADDRESSSIZE, 10, UB address width; depth is 2^ADDRESSSIZE words
- WORDSIZE, 64, UB word width (8 bytes)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command pulse; sampled only in IDLE
- base_addr  in  ADDRESSSIZE  first word address; sampled with start
- length  in  ADDRESSSIZE+1  word count, 0..2^ADDRESSSIZE; sampled with start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse when the command completes
- ub_rd_en  out  1  high in every cycle a read is issued; the arbiter holds UB write_enable low in these cycles
- ub_address  out  ADDRESSSIZE  registered read address
- ub_data_out  in  WORDSIZE  UB registered read data; valid the cycle after issue
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accept
- out_data  out  WORDSIZE  stream word
- out_last  out  1  high with the final word of the command

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - With start=1, latch base_addr and length.
  - length==0: stay in IDLE and pulse done in the next cycle. No reads, no stream words.
  - Otherwise go to RUN.
  - start is ignored in RUN and DRAIN.
- RUN:
  - Issue a read when issue_left>0 and fifo_count + inflight < 3. inflight is 1 if a read was issued the previous cycle.
  - There is no combinational path from out_ready to ub_rd_en or ub_address.
  - On each issue, ub_address increments by 1 modulo 2^ADDRESSSIZE (1023 wraps to 0) and issue_left decrements.
  - Go to DRAIN when the last read is issued.
- Read-data capture:
  - In the cycle after an issue, ub_data_out is pushed into the FIFO.
  - The FIFO entry carries a last flag, set on the word for the final issue.
- Stream:
  - The FIFO head drives out_data and out_last; out_valid = (fifo_count != 0).
  - A pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle are allowed; fifo_count is unchanged.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- DRAIN:
  - On the pop of the last-flagged word, go to IDLE and pulse done in the following cycle.
  - busy falls in the same cycle that done is high.
- Overflow: the FIFO never overflows, because the issue rule reserves a slot for the in-flight read.
- Reset, including mid-command:
  - Go to IDLE and flush the FIFO.
  - busy, done, ub_rd_en, out_valid, out_last = 0; ub_address = 0; out_data = 0.
  - The interrupted command is discarded and no done is pulsed.

## Timing
- Start accepted at edge E0:
  - busy=1 and the first ub_rd_en with ub_address=base_addr in cycle 1.
  - Data on ub_data_out in cycle 2, pushed at the end of cycle 2.
  - out_valid=1 in cycle 3.
- Latency from start to first out_valid: 3 cycles.
- With out_ready held high, one word per cycle. The last word of length N is out in cycle N+2 and done is in cycle N+3.
- A new start is accepted in the done cycle at the earliest (IDLE). Back-to-back commands therefore have a 1-cycle gap after done.
- After out_ready deasserts, at most 3 words are buffered and reads stop. Reads resume the cycle after fifo_count + inflight drops below 3.

## Test plan
- base=10, length=4, out_ready=1:
  - ub_address 10..13 in cycles 1-4.
  - Words mem[10..13] in cycles 3-6, with out_last only in cycle 6.
  - done in cycle 7; busy high in cycles 1-6.
- base=0, length=8, out_ready toggling 1/0 each cycle plus a stall of 5 cycles:
  - All 8 words delivered in order, none lost or duplicated.
  - ub_rd_en stops once 3 words are held.
  - out_data is stable while stalled.
- length=0: no ub_rd_en, no out_valid, done one cycle after start, busy stays 0.
- base=1022, length=4: addresses 1022, 1023, 0, 1, with data matching the preloaded words.
- start re-pulsed with different base/length while busy: ignored; the original stream completes unchanged.
- rst_n low in the middle of a length=16 run, after 5 words:
  - All outputs 0 immediately (asynchronous), no done.
  - After release, a new base=100, length=2 command streams mem[100..101] correctly.
